// File: rtl/data_mem_responder.sv
// Word-addressed RAM serving instruction fetch, byte-lane stores and latency-timed loads.
// Define MEM_BOUNDS_CHECK_EN to drop/zero accesses at or beyond DEPTH_WORDS and flag faulting loads.
module data_mem_responder #(
  parameter int ADDR_WIDTH   = 31,
  parameter int DATA_WIDTH   = 31,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2,
  parameter     INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH:0]   i_read_fetch_addr,
  output logic [DATA_WIDTH:0]   o_read_fetch_data,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  output logic                  o_read_ready,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [DATA_WIDTH:0] mem [DEPTH_WORDS];

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                idxOk_q;
  logic [DATA_WIDTH:0] readData_q;
  logic                ready_q;
  logic                fault_q;
  logic [DATA_WIDTH:0] fetchData_q;

  logic [IDX_W-1:0]    fetchIdx, reqIdx, wrIdx, respIdx;
  logic                fetchOk, reqOk, wrOk, respOk;
  logic                writeFire;
  logic [DATA_WIDTH:0] respWord;

  assign fetchIdx = i_read_fetch_addr[IDX_W-1:0];
  assign reqIdx   = i_read_addr[IDX_W-1:0];
  assign wrIdx    = i_write_addr[IDX_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign fetchOk = (i_read_fetch_addr[ADDR_WIDTH:IDX_W] == '0);
  assign reqOk   = (i_read_addr[ADDR_WIDTH:IDX_W] == '0);
  assign wrOk    = (i_write_addr[ADDR_WIDTH:IDX_W] == '0);
`else
  // Upper address bits alias onto the array when no range check is built in.
  logic unusedHighAddr;
  assign unusedHighAddr = ^{i_read_fetch_addr[ADDR_WIDTH:IDX_W],
                            i_read_addr[ADDR_WIDTH:IDX_W],
                            i_write_addr[ADDR_WIDTH:IDX_W]};
  assign fetchOk = 1'b1;
  assign reqOk   = 1'b1;
  assign wrOk    = 1'b1;
`endif

  assign writeFire = clk_en & i_write_enable & wrOk;
  assign respIdx   = (state_q == IDLE) ? reqIdx : idx_q;
  assign respOk    = (state_q == IDLE) ? reqOk  : idxOk_q;

  always_ff @(posedge clk) begin
    if (writeFire) begin
      for (int k = 0; k < 4; k++) begin
        if (i_byte_enable[k]) mem[wrIdx][8*k +: 8] <= i_write_data[8*k +: 8];
      end
    end
  end

  // Load response is write-first: lanes stored on the RESP-entry edge are merged in.
  always_comb begin
    respWord = mem[respIdx];
    if (writeFire && (wrIdx == respIdx)) begin
      for (int k = 0; k < 4; k++) begin
        if (i_byte_enable[k]) respWord[8*k +: 8] = i_write_data[8*k +: 8];
      end
    end
    if (!respOk) respWord = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchData_q <= '0;
    end else if (clk_en) begin
      fetchData_q <= fetchOk ? mem[fetchIdx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      idxOk_q    <= 1'b0;
      readData_q <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (i_read_req) begin
            idx_q   <= reqIdx;
            idxOk_q <= reqOk;
            if (READ_LATENCY == 1) begin
              state_q    <= RESP;
              readData_q <= respWord;
              ready_q    <= 1'b1;
              fault_q    <= ~reqOk;
            end else begin
              cnt_q   <= WAIT_INIT;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q    <= RESP;
            readData_q <= respWord;
            ready_q    <= 1'b1;
            fault_q    <= ~idxOk_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_read_fetch_data = fetchData_q;
  assign o_read_data       = readData_q;
  assign o_read_ready      = ready_q;
  assign o_fault           = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (READ_LATENCY=3) against a transaction-level model.
// Honours MEM_BOUNDS_CHECK_EN when the design is built with it.
module tb_data_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b0;
  logic [31:0] fetchAddr = '0;
  logic [31:0] fetchData;
  logic        readReq = 1'b0;
  logic [31:0] readAddr = '0;
  logic [31:0] readData;
  logic        readReady;
  logic        writeEn = 1'b0;
  logic [3:0]  byteEn = '0;
  logic [31:0] writeAddr = '0;
  logic [31:0] writeData = '0;
  logic        fault;

  data_mem_responder #(
    .ADDR_WIDTH(31), .DATA_WIDTH(31), .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clkEn),
    .i_read_fetch_addr(fetchAddr), .o_read_fetch_data(fetchData),
    .i_read_req(readReq), .i_read_addr(readAddr), .o_read_data(readData), .o_read_ready(readReady),
    .i_write_enable(writeEn), .i_byte_enable(byteEn), .i_write_addr(writeAddr),
    .i_write_data(writeData), .o_fault(fault)
  );

  always #5 clk = ~clk;

  logic [31:0] modelMem [DEPTH];
  bit          known [DEPTH];
  int          enCycle = 0;
  int          acceptCycle = 0;
  bit          pending = 0;
  bit          respPhase = 0;
  logic [31:0] pendAddr = '0;
  logic [31:0] expData = '0;
  logic [31:0] expFetch = '0;
  logic        expReady = 1'b0;
  logic        expFault = 1'b0;
  bit          fetchKnown = 1;
  int          checks = 0;
  int          failures = 0;

  function automatic bit inRange(logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return a < DEPTH;
`else
    return (a >= 0);
`endif
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 3)) << 10);
    return a;
  endfunction

  task automatic checkValue(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    pending = 0; respPhase = 0;
    expReady = 1'b0; expFault = 1'b0; expData = '0; expFetch = '0; fetchKnown = 1;
  endtask

  // One enabled clock edge: fetch sees the old word, loads complete LAT enabled cycles after accept.
  task automatic modelEdge();
    logic [9:0] wi;
    if (rst || !clkEn) return;
    enCycle++;
    if (inRange(fetchAddr)) begin
      expFetch = modelMem[fetchAddr[9:0]];
      fetchKnown = known[fetchAddr[9:0]];
    end else begin
      expFetch = '0;
      fetchKnown = 1;
    end
    if (writeEn && inRange(writeAddr)) begin
      wi = writeAddr[9:0];
      for (int k = 0; k < 4; k++)
        if (byteEn[k]) modelMem[wi][8*k +: 8] = writeData[8*k +: 8];
      if (byteEn == 4'hF) known[wi] = 1;
    end
    if (respPhase) begin
      respPhase = 0; expReady = 1'b0; expFault = 1'b0;
    end else if (!pending && readReq) begin
      pending = 1; acceptCycle = enCycle; pendAddr = readAddr;
    end
    if (pending && enCycle == acceptCycle + LAT - 1) begin
      pending = 0; respPhase = 1; expReady = 1'b1;
      if (inRange(pendAddr)) begin
        expData = modelMem[pendAddr[9:0]]; expFault = 1'b0;
      end else begin
        expData = '0; expFault = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("ready", 32'(readReady), 32'(expReady));
    checkValue("fault", 32'(fault), 32'(expFault));
    checkValue("readData", readData, expData);
    if (fetchKnown) checkValue("fetchData", fetchData, expFetch);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic writeWord(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    writeEn = 1'b1; writeAddr = a; writeData = d; byteEn = be;
    applyStimulus();
    writeEn = 1'b0; byteEn = '0;
  endtask

  // Issue a load, hold the request until ready, and report latency plus returned values.
  task automatic doLoad(logic [31:0] a, output int cycles, output logic [31:0] d, output logic f);
    bit seen;
    readReq = 1'b1; readAddr = a; cycles = -1; seen = 0; d = '0; f = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      applyStimulus();
      if (readReady === 1'b1) begin
        seen = 1; cycles = n; d = readData; f = fault;
      end
    end
    readReq = 1'b0;
    applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          cycles;
    int          strobes;
    int          loadsDone;
    bit          reqActive;
    bit          lastEn;
    bit          seen;
    logic [31:0] d;
    logic        f;

    modelReset();
    applyStimulus();
    checkValue("resetReady", 32'(readReady), 32'd0);
    checkValue("resetData", readData, 32'd0);
    checkValue("resetFetch", fetchData, 32'd0);
    checkValue("resetFault", 32'(fault), 32'd0);
    rst = 1'b0; clkEn = 1'b1;

    for (int i = 0; i < 32; i++) writeWord(32'(i), $urandom, 4'hF);
    writeWord(32'h04, 32'h0404A5A5, 4'hF);
    writeWord(32'h08, 32'h12345678, 4'hF);

    doLoad(32'h04, cycles, d, f);
    checkValue("latency", 32'(cycles), 32'(LAT));
    checkValue("latencyData", d, 32'h0404A5A5);

    writeWord(32'h10, 32'h11223344, 4'hF);
    writeWord(32'h10, 32'h0000AB00, 4'b0010);
    writeWord(32'h10, 32'hFFFFFFFF, 4'b0000);
    doLoad(32'h10, cycles, d, f);
    checkValue("byteLane", d, 32'h1122AB44);

    // clk_en held low for two cycles while the load is waiting
    readReq = 1'b1; readAddr = 32'h04;
    applyStimulus();
    cycles = 1;
    clkEn = 1'b0;
    applyStimulus(); applyStimulus();
    cycles += 2;
    clkEn = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      applyStimulus();
      cycles++;
      if (readReady === 1'b1) seen = 1;
    end
    if (!seen) cycles = -1;
    readReq = 1'b0;
    checkValue("stallLatency", 32'(cycles), 32'(LAT + 2));
    checkValue("stallData", readData, 32'h0404A5A5);
    clkEn = 1'b0;
    applyStimulus();
    checkValue("stallHoldReady", 32'(readReady), 32'd1);
    checkValue("stallHoldData", readData, 32'h0404A5A5);
    clkEn = 1'b1;
    applyStimulus();

    fetchAddr = 32'h08; readReq = 1'b1; readAddr = 32'h08;
    applyStimulus();
    applyStimulus();
    writeEn = 1'b1; writeAddr = 32'h08; writeData = 32'hDEADBEEF; byteEn = 4'hF;
    applyStimulus();
    writeEn = 1'b0; byteEn = '0; readReq = 1'b0;
    checkValue("fwdReady", 32'(readReady), 32'd1);
    checkValue("fwdData", readData, 32'hDEADBEEF);
    checkValue("fwdFetchOld", fetchData, 32'h12345678);
    applyStimulus();
    checkValue("fwdFetchNew", fetchData, 32'hDEADBEEF);

`ifdef MEM_BOUNDS_CHECK_EN
    d = modelMem[0];
    writeWord(32'h400, 32'hCAFEF00D, 4'hF);
    doLoad(32'h000, cycles, readAddr, f);
    checkValue("oobStoreDropped", dut.o_read_data, d);
    doLoad(32'h400, cycles, d, f);
    checkValue("oobLoadData", d, 32'd0);
    checkValue("oobLoadFault", 32'(f), 32'd1);
`else
    writeWord(32'h400, 32'hCAFEF00D, 4'hF);
    doLoad(32'h000, cycles, d, f);
    checkValue("aliasData", d, 32'hCAFEF00D);
    checkValue("aliasFault", 32'(f), 32'd0);
`endif

    // asynchronous reset while a load is waiting abandons it
    readReq = 1'b1; readAddr = 32'h04;
    applyStimulus();
    #2 rst = 1'b1;
    #1;
    checkValue("rstWaitReady", 32'(readReady), 32'd0);
    checkValue("rstWaitData", readData, 32'd0);
    checkValue("rstWaitFetch", fetchData, 32'd0);
    modelReset();
    readReq = 1'b0;
    applyStimulus();
    rst = 1'b0;
    strobes = 0;
    for (int n = 0; n < 6; n++) begin
      applyStimulus();
      if (readReady === 1'b1) strobes++;
    end
    checkValue("rstNoStrobe", 32'(strobes), 32'd0);

    reqActive = 0; loadsDone = 0;
    for (int i = 0; i < 400; i++) begin
      lastEn = clkEn;
      if (lastEn) begin
        if (reqActive && readReady === 1'b1) begin
          loadsDone++;
          if ($urandom_range(0, 1) == 1) readAddr = randAddr();
          else reqActive = 0;
        end else if (!reqActive && $urandom_range(0, 2) == 0) begin
          reqActive = 1; readAddr = randAddr();
        end
      end
      readReq   = reqActive;
      clkEn     = ($urandom_range(0, 4) != 0);
      writeEn   = ($urandom_range(0, 1) == 1);
      writeAddr = randAddr();
      writeData = $urandom;
      byteEn    = 4'($urandom);
      fetchAddr = randAddr();
      applyStimulus();
    end
    checkValue("randomLoadsSeen", 32'(loadsDone > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
